// File: rtl/ingress_frame_writer_pkg.sv
// Shared ingress types: receive bus, frame descriptor, writer FSM states.
package ingress_frame_writer_pkg;

   localparam int unsigned LEN_W       = 11;
   localparam int unsigned WCNT_W      = 12;
   localparam int unsigned DESC_ADDR_W = 16;

   // Byte-wide receive bus from the MAC side.
   typedef struct packed {
      logic       valid;
      logic [7:0] data;
      logic       last;
      logic       err;
   } EthernetRxBus;

   // Descriptor handed to the forwarding stage.
   typedef struct packed {
      logic [DESC_ADDR_W-1:0] addr;
      logic [LEN_W-1:0]       bytelen;
   } IngressDescriptor;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COPY = 2'd1,
      ST_DROP = 2'd2,
      ST_DESC = 2'd3
   } wr_state_e;

   // Number of 32-bit words covering a byte length (rounded up).
   function automatic logic [WCNT_W-1:0] word_count(input logic [LEN_W-1:0] bytelen);
      logic [WCNT_W-1:0] sum;
      sum = WCNT_W'(bytelen) + WCNT_W'(3);
      return sum >> 2;
   endfunction

endpackage

// File: rtl/ingress_frame_writer.sv
// Pops complete frames from the CDC, copies them into the packet buffer and
// emits one descriptor per stored frame; frames that do not fit are drained.
module ingress_frame_writer
   import ingress_frame_writer_pkg::*;
#(
   parameter int unsigned BUF_ADDR_BITS   = 10,
   parameter int unsigned MAX_FRAME_BYTES = 1536
) (
   input  logic                     clk_mem,
   input  logic                     rst_n,
   input  logic                     mem_frame_ready,
   input  logic [LEN_W-1:0]         mem_frame_bytelen,
   output logic                     mem_frame_start,
   input  logic                     mem_valid,
   input  logic [31:0]              mem_data,
   input  logic                     mem_frame_done,
   output logic                     buf_wr_en,
   output logic [BUF_ADDR_BITS-1:0] buf_wr_addr,
   output logic [31:0]              buf_wr_data,
   output logic                     desc_valid,
   input  logic                     desc_ready,
   output logic [BUF_ADDR_BITS-1:0] desc_addr,
   output logic [LEN_W-1:0]         desc_bytelen,
   input  logic                     rel_valid,
   input  logic [BUF_ADDR_BITS:0]   rel_words,
   output logic [15:0]              frames_ok,
   output logic [15:0]              frames_dropped
);

   localparam int unsigned FREE_W = BUF_ADDR_BITS + 1;
   localparam int unsigned NET_W  = BUF_ADDR_BITS + 2;
   localparam logic [FREE_W-1:0] DEPTH = {1'b1, {BUF_ADDR_BITS{1'b0}}};

   wr_state_e               state;
   wr_state_e               state_d;
   logic [BUF_ADDR_BITS-1:0] wr_ptr;
   logic [BUF_ADDR_BITS-1:0] base;
   logic [LEN_W-1:0]         len_lat;
   logic [WCNT_W-1:0]        w_lat;
   logic [WCNT_W-1:0]        wcnt;
   logic [FREE_W-1:0]        free_words;
   logic [FREE_W-1:0]        free_d;
   logic [NET_W-1:0]         net;
   logic [WCNT_W-1:0]        frame_w;
   logic                     len_ok;
   logic                     fits;
   logic                     reserve;
   logic                     desc_hs;
   logic                     drop_done;

   assign frame_w = word_count(mem_frame_bytelen);
   assign len_ok  = (mem_frame_bytelen != '0) &&
                    (32'(mem_frame_bytelen) <= 32'(MAX_FRAME_BYTES));
   assign fits    = 32'(frame_w) <= 32'(free_words);

   assign buf_wr_addr  = wr_ptr;
   assign buf_wr_data  = mem_data;
   assign desc_addr    = base;
   assign desc_bytelen = len_lat;

   // State register.
   always_ff @(posedge clk_mem or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_d;
   end

   // Next state and per-cycle strobes.
   always_comb begin
      state_d         = state;
      mem_frame_start = 1'b0;
      buf_wr_en       = 1'b0;
      desc_valid      = 1'b0;
      reserve         = 1'b0;
      desc_hs         = 1'b0;
      drop_done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_frame_ready) begin
               mem_frame_start = 1'b1;
               if (len_ok && fits) begin
                  reserve = 1'b1;
                  state_d = ST_COPY;
               end else begin
                  state_d = ST_DROP;
               end
            end
         end
         ST_COPY: begin
            // Words past the reserved count are silently discarded.
            buf_wr_en = mem_valid && (wcnt < w_lat);
            if (mem_frame_done) state_d = ST_DESC;
         end
         ST_DROP: begin
            if (mem_frame_done) begin
               drop_done = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_DESC: begin
            desc_valid = 1'b1;
            if (desc_ready) begin
               desc_hs = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Net free-space update: release and reservation may land together.
   always_comb begin
      net = NET_W'(free_words);
      if (rel_valid) net = net + NET_W'(rel_words);
      if (reserve)   net = net - NET_W'(frame_w);
      free_d = (net > NET_W'(DEPTH)) ? DEPTH : FREE_W'(net);
   end

   // Frame latches, write pointer, free space and event counters.
   always_ff @(posedge clk_mem or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr         <= '0;
         base           <= '0;
         len_lat        <= '0;
         w_lat          <= '0;
         wcnt           <= '0;
         free_words     <= DEPTH;
         frames_ok      <= '0;
         frames_dropped <= '0;
      end else begin
         free_words <= free_d;
         if (mem_frame_start) begin
            base    <= wr_ptr;
            len_lat <= mem_frame_bytelen;
            w_lat   <= frame_w;
            wcnt    <= '0;
         end
         if (buf_wr_en) begin
            wr_ptr <= wr_ptr + BUF_ADDR_BITS'(1);
            wcnt   <= wcnt + WCNT_W'(1);
         end
         // Short frames still consume their full reservation.
         if (desc_hs) begin
            wr_ptr    <= base + BUF_ADDR_BITS'(w_lat);
            frames_ok <= frames_ok + 16'd1;
         end
         if (drop_done) frames_dropped <= frames_dropped + 16'd1;
      end
   end

endmodule

// File: tb/tb_ingress_frame_writer.sv
// Self-checking bench for ingress_frame_writer: frame table plus corner sequences.
module tb_ingress_frame_writer;

   localparam int ABITS = 10;
   localparam int DEPTH = 1024;

   logic             clk_mem = 1'b0;
   logic             rst_n   = 1'b0;
   logic             mem_frame_ready = 1'b0;
   logic [10:0]      mem_frame_bytelen = '0;
   logic             mem_frame_start;
   logic             mem_valid = 1'b0;
   logic [31:0]      mem_data = '0;
   logic             mem_frame_done = 1'b0;
   logic             buf_wr_en;
   logic [ABITS-1:0] buf_wr_addr;
   logic [31:0]      buf_wr_data;
   logic             desc_valid;
   logic             desc_ready = 1'b1;
   logic [ABITS-1:0] desc_addr;
   logic [10:0]      desc_bytelen;
   logic             rel_valid = 1'b0;
   logic [ABITS:0]   rel_words = '0;
   logic [15:0]      frames_ok;
   logic [15:0]      frames_dropped;

   ingress_frame_writer #(.BUF_ADDR_BITS(ABITS), .MAX_FRAME_BYTES(1536)) dut (
      .clk_mem(clk_mem), .rst_n(rst_n),
      .mem_frame_ready(mem_frame_ready), .mem_frame_bytelen(mem_frame_bytelen),
      .mem_frame_start(mem_frame_start), .mem_valid(mem_valid), .mem_data(mem_data),
      .mem_frame_done(mem_frame_done), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
      .buf_wr_data(buf_wr_data), .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_addr(desc_addr), .desc_bytelen(desc_bytelen), .rel_valid(rel_valid),
      .rel_words(rel_words), .frames_ok(frames_ok), .frames_dropped(frames_dropped)
   );

   always #5 clk_mem = ~clk_mem;

   typedef struct { int addr; logic [31:0] data; } wr_t;
   typedef struct { int addr; int len; } dsc_t;
   typedef struct { int bytelen; int nsent; bit accept; int base; int free_after; } vec_t;

   wr_t  wq[$];
   dsc_t dq[$];
   wr_t  mon_w;
   dsc_t mon_d;
   int   total = 0;
   int   bad = 0;
   int   start_cnt = 0;
   int   exp_ok = 0, exp_drop = 0, exp_starts = 0;
   logic [31:0] fixed_words [5];
   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_mem);
      #1;
   endtask

   // Write and descriptor scoreboard, sampled on the falling edge.
   always @(negedge clk_mem) begin
      if (mem_frame_start) start_cnt++;
      if (buf_wr_en) begin
         if (wq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write actual addr=%0d required none", buf_wr_addr);
         end else begin
            mon_w = wq.pop_front();
            check("wr_addr", 32'(buf_wr_addr), mon_w.addr);
            check("wr_data", buf_wr_data, mon_w.data);
         end
      end
      if (desc_valid && desc_ready) begin
         if (dq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_desc actual addr=%0d required none", desc_addr);
         end else begin
            mon_d = dq.pop_front();
            check("desc_addr", 32'(desc_addr), mon_d.addr);
            check("desc_bytelen", 32'(desc_bytelen), mon_d.len);
         end
      end
   end

   task automatic wait_start();
      bit seen = 0;
      for (int t = 0; t < 400 && !seen; t++) begin
         @(negedge clk_mem);
         if (mem_frame_start) seen = 1;
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL start_timeout actual=none required=mem_frame_start");
      end
   endtask

   task automatic wait_counts();
      bit done = 0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk_mem);
         if (frames_ok == 16'(exp_ok) && frames_dropped == 16'(exp_drop)) done = 1;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL frame_timeout actual ok=%0d drop=%0d required ok=%0d drop=%0d",
                  frames_ok, frames_dropped, exp_ok, exp_drop);
      end
   endtask

   task automatic drive_words(input int nsent, input int w, input bit accept,
                              input int base, input bit fixed, input bit with_done);
      wr_t e;
      for (int i = 0; i < nsent; i++) begin
         e.data = fixed ? fixed_words[i] : $urandom;
         e.addr = (base + i) % DEPTH;
         if (accept && i < w) wq.push_back(e);
         mem_valid      = 1'b1;
         mem_data       = e.data;
         mem_frame_done = with_done && (i == nsent - 1);
         tick();
      end
      mem_valid      = 1'b0;
      mem_frame_done = 1'b0;
   endtask

   task automatic send_frame(input int bytelen, input int nsent, input bit accept,
                             input int base, input int rel_start, input bit fixed);
      dsc_t d;
      tick();
      mem_frame_ready   = 1'b1;
      mem_frame_bytelen = 11'(bytelen);
      if (rel_start > 0) begin
         rel_valid = 1'b1;
         rel_words = 11'(rel_start);
      end
      wait_start();
      tick();
      mem_frame_ready = 1'b0;
      rel_valid       = 1'b0;
      rel_words       = '0;
      exp_starts++;
      if (accept) begin
         exp_ok++;
         d.addr = base;
         d.len  = bytelen;
         dq.push_back(d);
      end else begin
         exp_drop++;
      end
      drive_words(nsent, (bytelen + 3) / 4, accept, base, fixed, 1'b1);
      wait_counts();
   endtask

   task automatic release_words(input int n);
      tick();
      rel_valid = 1'b1;
      rel_words = 11'(n);
      tick();
      rel_valid = 1'b0;
      rel_words = '0;
      @(negedge clk_mem);
   endtask

   task automatic do_reset();
      mem_frame_ready = 1'b0;
      mem_valid       = 1'b0;
      mem_frame_done  = 1'b0;
      rel_valid       = 1'b0;
      desc_ready      = 1'b1;
      rst_n           = 1'b0;
      repeat (3) tick();
      check("rst_start", 32'(mem_frame_start), 0);
      check("rst_wr_en", 32'(buf_wr_en), 0);
      check("rst_desc_valid", 32'(desc_valid), 0);
      check("rst_frames_ok", 32'(frames_ok), 0);
      check("rst_frames_dropped", 32'(frames_dropped), 0);
      check("rst_free", 32'(dut.free_words), DEPTH);
      check("rst_wr_ptr", 32'(dut.wr_ptr), 0);
      rst_n = 1'b1;
      tick();
      exp_ok = 0; exp_drop = 0; exp_starts = 0; start_cnt = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      fixed_words[0] = 32'hfeedface; fixed_words[1] = 32'hdeadbeef;
      fixed_words[2] = 32'hcafef00d; fixed_words[3] = 32'hbaadc0de;
      fixed_words[4] = 32'h41414100;
      // bytelen, words sent, accepted, base, free after
      vecs[0] = '{19,   5,   1'b1, 0,  1019};
      vecs[1] = '{32,   8,   1'b1, 5,  1011};
      vecs[2] = '{4,    1,   1'b1, 13, 1010};
      vecs[3] = '{0,    1,   1'b0, 0,  1010};
      vecs[4] = '{1537, 2,   1'b0, 0,  1010};
      vecs[5] = '{12,   5,   1'b1, 14, 1007};
      vecs[6] = '{16,   2,   1'b1, 17, 1003};
      vecs[7] = '{1,    1,   1'b1, 21, 1002};
      vecs[8] = '{1536, 384, 1'b1, 22, 618};

      do_reset();
      release_words(5);
      check("free_saturate", 32'(dut.free_words), DEPTH);

      for (int i = 0; i < 9; i++) begin
         send_frame(vecs[i].bytelen, vecs[i].nsent, vecs[i].accept, vecs[i].base, 0, i == 0);
         check("frames_ok", 32'(frames_ok), exp_ok);
         check("frames_dropped", 32'(frames_dropped), exp_drop);
         check("free_words", 32'(dut.free_words), vecs[i].free_after);
         check("start_count", start_cnt, exp_starts);
      end

      // Descriptor back-pressure with the next frame already pending.
      tick();
      desc_ready        = 1'b0;
      mem_frame_ready   = 1'b1;
      mem_frame_bytelen = 11'd8;
      wait_start();
      tick();
      mem_frame_bytelen = 11'd4;
      exp_starts++; exp_ok++;
      mon_d.addr = 406; mon_d.len = 8; dq.push_back(mon_d);
      drive_words(2, 2, 1'b1, 406, 1'b0, 1'b1);
      s = start_cnt;
      repeat (20) begin
         @(negedge clk_mem);
         check("stall_desc_valid", 32'(desc_valid), 1);
         check("stall_desc_addr", 32'(desc_addr), 406);
         check("stall_desc_len", 32'(desc_bytelen), 8);
         check("stall_no_start", 32'(mem_frame_start), 0);
      end
      check("stall_start_count", start_cnt, s);
      tick();
      desc_ready = 1'b1;
      @(negedge clk_mem);
      check("hs_cycle_no_start", 32'(mem_frame_start), 0);
      @(negedge clk_mem);
      check("start_after_hs", 32'(mem_frame_start), 1);
      tick();
      mem_frame_ready = 1'b0;
      exp_starts++; exp_ok++;
      mon_d.addr = 408; mon_d.len = 4; dq.push_back(mon_d);
      drive_words(1, 1, 1'b1, 408, 1'b0, 1'b1);
      wait_counts();
      check("stall_free", 32'(dut.free_words), 615);
      check("stall_starts", start_cnt, exp_starts);
      check("wq_drained_a", wq.size(), 0);
      check("dq_drained_a", dq.size(), 0);

      // Drop on insufficient space, then accept after release (with wrap).
      do_reset();
      send_frame(1536, 384, 1'b1, 0,   0, 1'b0);
      send_frame(1536, 384, 1'b1, 384, 0, 1'b0);
      send_frame(1012, 253, 1'b1, 768, 0, 1'b0);
      check("free_before_drop", 32'(dut.free_words), 3);
      send_frame(16, 4, 1'b0, 0, 0, 1'b0);
      check("nospace_dropped", 32'(frames_dropped), 1);
      check("nospace_free", 32'(dut.free_words), 3);
      release_words(8);
      check("free_after_rel", 32'(dut.free_words), 11);
      send_frame(16, 4, 1'b1, 1021, 2, 1'b0);
      check("net_update_free", 32'(dut.free_words), 9);
      check("wrap_ptr_b", 32'(dut.wr_ptr), 1);

      // Frame filling exactly the remaining space at the top of the buffer.
      do_reset();
      send_frame(1536, 384, 1'b1, 0,   0, 1'b0);
      send_frame(1536, 384, 1'b1, 384, 0, 1'b0);
      send_frame(1016, 254, 1'b1, 768, 0, 1'b0);
      check("ptr_1022", 32'(dut.wr_ptr), 1022);
      check("free_2", 32'(dut.free_words), 2);
      send_frame(8, 2, 1'b1, 1022, 0, 1'b0);
      check("exact_fit_free", 32'(dut.free_words), 0);
      check("wrap_ptr_c", 32'(dut.wr_ptr), 0);
      release_words(8);
      send_frame(4, 1, 1'b1, 0, 0, 1'b0);
      check("after_wrap_free", 32'(dut.free_words), 7);
      check("after_wrap_ptr", 32'(dut.wr_ptr), 1);

      // Reset in the middle of a copy.
      do_reset();
      tick();
      mem_frame_ready   = 1'b1;
      mem_frame_bytelen = 11'd32;
      wait_start();
      tick();
      mem_frame_ready = 1'b0;
      drive_words(3, 8, 1'b1, 0, 1'b0, 1'b0);
      mem_valid = 1'b1;
      rst_n     = 1'b0;
      #1;
      check("midrst_wr_en", 32'(buf_wr_en), 0);
      check("midrst_desc", 32'(desc_valid), 0);
      do_reset();
      repeat (3) begin
         @(negedge clk_mem);
         check("post_rst_desc", 32'(desc_valid), 0);
      end
      check("post_rst_ptr", 32'(dut.wr_ptr), 0);
      check("post_rst_free", 32'(dut.free_words), DEPTH);
      check("post_rst_ok", 32'(frames_ok), 0);
      check("wq_drained_b", wq.size(), 0);
      check("dq_drained_b", dq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
